// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned IN_W   = 8;
    localparam int unsigned DIGITS = 3;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/dabble_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more, no carry out.
module dabble_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready handshakes.
// Optional BIN2BCD_ZERO_FAST_EN: a zero operand skips the shift phase entirely.
module bin_to_bcd_seq #(
    parameter int unsigned IN_W   = bcd_pkg::IN_W,
    parameter int unsigned DIGITS = bcd_pkg::DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd
);
    import bcd_pkg::*;

    localparam int unsigned CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    state_e             r_state, w_state_nxt;
    logic [BCD_W-1:0]   r_bcd, w_bcd_nxt, w_bcd_adj;
    logic [IN_W-1:0]    r_bin, w_bin_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        dabble_adj u_adj (
            .i_digit (r_bcd[4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bcd   <= w_bcd_nxt;
            r_bin   <= w_bin_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcd_nxt   = r_bcd;
        w_bin_nxt   = r_bin;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_bin_nxt = in_data;
                    w_bcd_nxt = '0;
                    w_cnt_nxt = '0;
`ifdef BIN2BCD_ZERO_FAST_EN
                    w_state_nxt = (in_data == '0) ? DONE : SHIFT;
`else
                    w_state_nxt = SHIFT;
`endif
                end
            end
            SHIFT: begin
                // Correct every digit first, then shift the whole BCD:binary chain.
                {w_bcd_nxt, w_bin_nxt} = {w_bcd_adj, r_bin} << 1;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign bcd       = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: latency, result, hold, ignore and reset behaviour.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;

    int unsigned n_vec;
    int unsigned n_err;
    logic [11:0] exp_q[$];

    bin_to_bcd_seq #(.IN_W(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] bcd_model(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic int exp_latency(input logic [7:0] d);
`ifdef BIN2BCD_ZERO_FAST_EN
        if (d == 8'd0) return 1;
`endif
        return 9;
    endfunction

    // Called at a negedge; returns at a negedge with the result consumed or pending exit.
    task automatic convert(input logic [7:0] d, input int hold, input bit keep_valid);
        int budget;
        int lat;
        logic [11:0] exp_bcd;
        budget = 0;
        while (!in_ready && budget < 30) begin
            @(negedge clk);
            budget++;
        end
        check_eq("ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(bcd_model(int'(d)));
        @(posedge clk);
        #1;
        if (keep_valid) in_data = 8'd7;
        else            in_valid = 1'b0;
        out_ready = (hold == 0);
        lat = 0;
        do begin
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 30);
        check_eq("latency", 32'(lat), 32'(exp_latency(d)));
        in_valid = 1'b0;
        in_data  = 8'd0;
        exp_bcd = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
        check_eq("bcd", {20'd0, bcd}, {20'd0, exp_bcd});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_bcd", {20'd0, bcd}, {20'd0, exp_bcd});
        end
        if (hold > 0) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_eq("release_ready", {31'd0, in_ready}, 32'd1);
            check_eq("release_valid", {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        int stray;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        n_vec     = 0;
        n_err     = 0;
        #3;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_bcd", {20'd0, bcd}, 32'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        convert(8'd255, 0, 1'b0);
        convert(8'd99, 0, 1'b0);
        convert(8'd100, 0, 1'b0);
        convert(8'd5, 0, 1'b0);
        convert(8'd0, 0, 1'b0);
        convert(8'd128, 5, 1'b0);

        // Operand offered during SHIFT must be neither converted nor queued.
        convert(8'd200, 0, 1'b1);
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check_eq("ignored_operand", 32'(stray), 32'd0);

        // Reset mid-conversion after four shift edges.
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd123;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("async_rst_bcd", {20'd0, bcd}, 32'h000);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check_eq("no_valid_after_rst", 32'(stray), 32'd0);

        for (int v = 0; v < 256; v++) begin
            convert(8'(v), 0, 1'b0);
        end
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter: IN_W, default 8, binary input width; fixed at 8 in this revision.
REQ-002 Parameter: DIGITS, default 3, number of BCD digits produced.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  binary operand offered.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 in_data  input  IN_W  unsigned binary operand.
REQ-008 out_valid  output  1  conversion result available.
REQ-009 out_ready  input  1  downstream (2421 encoder stage) accepts result.
REQ-010 bcd  output  4*DIGITS  packed BCD result; [3:0] = units, [7:4] = tens, [11:8] = hundreds.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 Accept: on a clk edge in IDLE with in_valid=1, the block SHALL load bin_reg<=in_data, clear bcd_reg to 0, clear the 3-bit cnt, and enter SHIFT.
REQ-014 Each SHIFT cycle: every bcd_reg digit >=5 SHALL get +3 (4-bit, no carry between digits), then {bcd_reg,bin_reg} SHALL shift left by 1 and cnt SHALL increment.
REQ-015 When cnt==IN_W-1 at a SHIFT edge, the block SHALL perform that final step and enter DONE; SHIFT lasts exactly IN_W cycles.
REQ-016 Latency: out_valid SHALL rise IN_W+1 clk edges after the accept edge (9 for IN_W=8).
REQ-017 In DONE, bcd and out_valid SHALL hold stable while out_ready=0; on an edge with out_ready=1 the block SHALL return to IDLE.
REQ-018 Minimum operand spacing SHALL be IN_W+2 cycles; no acceptance in DONE even if out_ready=1 on the same edge.
REQ-019 in_valid/in_data while not in IDLE SHALL be ignored and not queued.
REQ-020 Every output digit SHALL be in 0..9 for all inputs 0..255; the hundreds digit SHALL be <=2.
REQ-021 bcd SHALL be driven from bcd_reg in all states; its value is only meaningful while out_valid=1.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, bcd_reg=0, bin_reg=0, cnt=0, independent of clk.
REQ-023 Reset values: in_ready=1, out_valid=0, bcd=12'h000.
REQ-024 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no out_valid pulse SHALL follow deassertion.

Configuration
REQ-025 Macro BIN2BCD_ZERO_FAST_EN: when defined, an accepted in_data==0 SHALL go directly IDLE->DONE with bcd=0, giving out_valid 1 edge after accept.
REQ-026 Without BIN2BCD_ZERO_FAST_EN, in_data==0 SHALL take the normal IN_W+1 latency.

Structure
REQ-027 Shared package bcd_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE), the BCD digit typedef (4 bits), and constants IN_W=8, DIGITS=3.
REQ-028 One sub-module, dabble_adj (4-bit in, 4-bit out: +3 if >=5), SHALL be instantiated DIGITS times.

Verification
REQ-029 in_data=8'd255, out_ready=1 -> out_valid 9 edges after accept, bcd=12'h255.
REQ-030 in_data=8'd99 -> bcd=12'h099; in_data=8'd100 -> bcd=12'h100; in_data=8'd5 -> bcd=12'h005.
REQ-031 in_data=0: with BIN2BCD_ZERO_FAST_EN -> out_valid after 1 edge, bcd=0; without it -> after 9 edges, bcd=0.
REQ-032 Result 12'h128 (in_data=128), out_ready=0 for 5 cycles -> out_valid and bcd hold; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 in_valid=1 with in_data=8'd7 during SHIFT of operand 200 -> result 12'h200, 7 never converted.
REQ-034 rst_n pulsed low at SHIFT cycle 4 -> outputs at reset values asynchronously, no out_valid afterwards; exhaustive sweep 0..255 afterwards matches a decimal reference model.
